// File: rtl/bcd_scan_driver.sv
// Four-digit multiplexed seven-segment driver for BCD values.
// A new value is latched only at frame boundaries, so one scan frame never shows a mix of old and new digits.
module bcd_scan_driver #(
  parameter int SCAN_DIV   = 100000,
  parameter int SCAN_WIDTH = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bcd_in,
  input  logic        bcd_valid,
  input  logic        blank_en,
  output logic [3:0]  an,
  output logic [6:0]  cat,
  output logic        frame_done,
  output logic        bad_digit
);

  localparam logic [SCAN_WIDTH-1:0] PRESC_LAST = SCAN_WIDTH'(SCAN_DIV - 1);
  localparam logic [6:0]            CAT_OFF    = 7'b1111111;

  logic [SCAN_WIDTH-1:0] presc_q, presc_d;
  logic [1:0]            idx_q, idx_d;
  logic [15:0]           display_q, display_d;
  logic [15:0]           pending_q, pending_d;
  logic                  pendFlag_q, pendFlag_d;
  logic [3:0]            an_q, an_d;
  logic [6:0]            cat_q, cat_d;
  logic                  frameDone_q;
  logic                  badDigit_q, badDigit_d;

  logic       tick;
  logic       boundary;
  logic [3:0] curDigit;
  logic       blankDigit;

  always_comb begin
    tick     = (presc_q == PRESC_LAST);
    boundary = tick && (idx_q == 2'd3);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
  end

  // A strobe landing on the boundary itself bypasses the pending register.
  always_comb begin
    display_d  = display_q;
    pending_d  = pending_q;
    pendFlag_d = pendFlag_q;
    if (boundary) begin
      if (bcd_valid) begin
        display_d  = bcd_in;
        pendFlag_d = 1'b0;
      end else if (pendFlag_q) begin
        display_d  = pending_q;
        pendFlag_d = 1'b0;
      end
    end else if (bcd_valid) begin
      pending_d  = bcd_in;
      pendFlag_d = 1'b1;
    end
  end

  always_comb begin
    curDigit   = display_q[15:12];
    blankDigit = 1'b0;
    case (idx_q)
      2'd0: begin
        curDigit   = display_q[15:12];
        blankDigit = blank_en && (display_q[15:12] == 4'd0);
      end
      2'd1: begin
        curDigit   = display_q[11:8];
        blankDigit = blank_en && (display_q[15:8] == 8'd0);
      end
      2'd2: begin
        curDigit   = display_q[7:4];
        blankDigit = blank_en && (display_q[15:4] == 12'd0);
      end
      default: begin
        curDigit   = display_q[3:0];
        blankDigit = 1'b0;
      end
    endcase
  end

  always_comb begin
    an_d       = ~(4'b1000 >> idx_q);
    badDigit_d = (curDigit > 4'd9);
    cat_d      = CAT_OFF;
    if (!blankDigit) begin
      case (curDigit)
        4'd0:    cat_d = 7'b1000000;
        4'd1:    cat_d = 7'b1111001;
        4'd2:    cat_d = 7'b0100100;
        4'd3:    cat_d = 7'b0110000;
        4'd4:    cat_d = 7'b0011001;
        4'd5:    cat_d = 7'b0010010;
        4'd6:    cat_d = 7'b0000010;
        4'd7:    cat_d = 7'b1111000;
        4'd8:    cat_d = 7'b0000000;
        4'd9:    cat_d = 7'b0010000;
        default: cat_d = CAT_OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q     <= '0;
      idx_q       <= 2'd0;
      display_q   <= 16'h0000;
      pending_q   <= 16'h0000;
      pendFlag_q  <= 1'b0;
      an_q        <= 4'b1111;
      cat_q       <= CAT_OFF;
      frameDone_q <= 1'b0;
      badDigit_q  <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      display_q   <= display_d;
      pending_q   <= pending_d;
      pendFlag_q  <= pendFlag_d;
      an_q        <= an_d;
      cat_q       <= cat_d;
      frameDone_q <= boundary;
      badDigit_q  <= badDigit_d;
    end
  end

  assign an         = an_q;
  assign cat        = cat_q;
  assign frame_done = frameDone_q;
  assign bad_digit  = badDigit_q;

endmodule
